// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB completer types and defaults
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        MISALIGNED   = 2'd1,
        OUT_OF_RANGE = 2'd2,
        RO_WRITE     = 2'd3
    } apb_err_cause_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between requester and completer
interface apb_slave_regfile_if #(
    parameter int DATA_WIDTH = apb_pkg::APB_DATA_W,
    parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_W
) ();
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - register index and legality decode of an APB address
module apb_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    output logic [IDX_W-1:0]      idx,
    output logic                  legal
);
    logic misaligned;
    logic out_of_range;
    logic ro_write;

    always_comb begin
        idx          = PADDR[2 +: IDX_W];
        misaligned   = |PADDR[1:0];
        out_of_range = |(PADDR >> (2 + IDX_W));
        // Top index holds the transfer counter and is never writable
        ro_write     = PWRITE && (idx == IDX_W'(NUM_REGS - 1));
        legal        = !misaligned && !out_of_range && !ro_write;
    end
endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with register bank, wait states and transfer counter
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_slave_regfile_if.slave  bus
);
    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]      WAIT_LD = 4'(WAIT_CYCLES);

    apb_state_t            state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [IDX_W-1:0]      idx;
    logic                  legal;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .PADDR  (bus.PADDR),
        .PWRITE (bus.PWRITE),
        .idx    (idx),
        .legal  (legal)
    );

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;

    // The counter lives in the top array slot; writes there are decoded illegal
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.PSELx && !bus.PENABLE) begin
                        state <= WAIT;
                        cnt   <= WAIT_LD;
                    end
                end
                WAIT: begin
                    if (!bus.PSELx) begin
                        state <= IDLE;
                    end else if (bus.PENABLE) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state     <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= !legal;
                            prdata_q  <= (legal && !bus.PWRITE) ? regs[idx] : '0;
                            if (legal) begin
                                if (bus.PWRITE) begin
                                    regs[idx] <= bus.PWDATA;
                                end
                                regs[CNT_IDX] <= regs[CNT_IDX] + 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (bus.PSELx && !bus.PENABLE) begin
                        state <= WAIT;
                        cnt   <= WAIT_LD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;
    import apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [2:0]  sel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    int          cur = 0;

    logic [31:0] rdata_m;
    logic        ready_m;
    logic        err_m;

    int checks = 0;
    int errors = 0;
    int cause_hits [4];

    logic [31:0] m_regs [3][16];
    logic [31:0] m_cnt  [3];
    int          exp_waits [3];

    always #5 PCLK = ~PCLK;

    apb_slave_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    apb_slave_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    apb_slave_regfile_if #(.DATA_WIDTH(4),  .ADDR_WIDTH(32)) bus2 ();

    assign bus0.PSELx = sel[0];  assign bus0.PENABLE = penable;
    assign bus0.PWRITE = pwrite; assign bus0.PADDR = paddr; assign bus0.PWDATA = pwdata;
    assign bus1.PSELx = sel[1];  assign bus1.PENABLE = penable;
    assign bus1.PWRITE = pwrite; assign bus1.PADDR = paddr; assign bus1.PWDATA = pwdata;
    assign bus2.PSELx = sel[2];  assign bus2.PENABLE = penable;
    assign bus2.PWRITE = pwrite; assign bus2.PADDR = paddr; assign bus2.PWDATA = pwdata[3:0];

    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(1))
        dut0 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus0));
    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0))
        dut1 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus1));
    apb_slave_regfile #(.DATA_WIDTH(4), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(3))
        dut2 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus2));

    always_comb begin
        case (cur)
            0: begin rdata_m = bus0.PRDATA; ready_m = bus0.PREADY; err_m = bus0.PSLVERR; end
            1: begin rdata_m = bus1.PRDATA; ready_m = bus1.PREADY; err_m = bus1.PSLVERR; end
            default: begin rdata_m = {28'd0, bus2.PRDATA}; ready_m = bus2.PREADY; err_m = bus2.PSLVERR; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = '0;
            for (int i = 0; i < 16; i++) m_regs[d][i] = '0;
        end
    endfunction

    function automatic void model_xfer(input int d, input bit wr, input logic [31:0] a,
                                       input logic [31:0] wd, output logic [31:0] erd,
                                       output bit eerr);
        int          idx;
        logic [31:0] mask;
        apb_err_cause_t cause;
        idx  = int'(a[5:2]);
        mask = (d == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
        if (a[1:0] != 2'b00)        cause = MISALIGNED;
        else if (a[31:6] != '0)     cause = OUT_OF_RANGE;
        else if (wr && idx == 15)   cause = RO_WRITE;
        else                        cause = CAUSE_NONE;
        cause_hits[int'(cause)]++;
        eerr = (cause != CAUSE_NONE);
        erd  = '0;
        if (!eerr) begin
            if (wr) m_regs[d][idx] = wd & mask;
            else    erd = (idx == 15) ? m_cnt[d] : m_regs[d][idx];
            m_cnt[d] = (m_cnt[d] + 1) & mask;
        end
    endfunction

    // Called right after a rising edge; returns right after the completing edge
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err, output int waits);
        #1;
        cur = d; sel = '0; sel[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = wd;
        @(posedge PCLK); #1 penable = 1'b1;
        waits = 0;
        forever begin
            @(negedge PCLK);
            if (ready_m) break;
            check("quiet_prdata", rdata_m, 32'd0);
            check("quiet_pslverr", {31'd0, err_m}, 32'd0);
            waits++;
            if (waits > 40) begin
                check("pready_timeout", 32'(waits), 32'(exp_waits[d]));
                break;
            end
        end
        rd = rdata_m; err = err_m;
        @(posedge PCLK);
    endtask

    task automatic idle();
        #1 sel = '0; penable = 1'b0;
        @(posedge PCLK);
    endtask

    task automatic do_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
        logic [31:0] erd;
        bit          eerr, err;
        int          waits;
        model_xfer(d, wr, a, wd, erd, eerr);
        xfer(d, wr, a, wd, rd, err, waits);
        check($sformatf("d%0d_a%h_prdata", d, a), rd, erd);
        check($sformatf("d%0d_a%h_pslverr", d, a), {31'd0, err}, {31'd0, eerr});
        check($sformatf("d%0d_waits", d), 32'(waits), 32'(exp_waits[d]));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        bit          wr;
        int          r;
        exp_waits[0] = 2; exp_waits[1] = 1; exp_waits[2] = 4;
        model_reset();

        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        for (int d = 0; d < 3; d++) begin
            cur = d; #1;
            check("reset_pready", {31'd0, ready_m}, 32'd0);
            check("reset_prdata", rdata_m, 32'd0);
            check("reset_pslverr", {31'd0, err_m}, 32'd0);
        end
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(posedge PCLK);

        // Wrap on the 4-bit instance before anything else touches its counter
        for (int i = 0; i < 16; i++) begin
            do_xfer(2, 1'b1, 32'h0000_0000, 32'(i), rd); idle();
        end
        do_xfer(2, 1'b0, 32'h0000_003C, 32'd0, rd); idle();
        check("wrap_counter", rd, 32'd0);

        do_xfer(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, rd); idle();
        do_xfer(0, 1'b0, 32'h0000_0004, 32'd0, rd); idle();
        check("rd_deadbeef", rd, 32'hDEAD_BEEF);
        do_xfer(0, 1'b0, 32'h0000_003C, 32'd0, rd); idle();
        check("counter_two", rd, 32'd2);

        do_xfer(1, 1'b1, 32'h0000_0010, 32'h1234_5678, rd);
        do_xfer(1, 1'b0, 32'h0000_0010, 32'd0, rd);
        do_xfer(1, 1'b0, 32'h0000_003C, 32'd0, rd); idle();
        check("b2b_readback_cnt", rd, 32'd2);

        do_xfer(0, 1'b1, 32'h0000_003C, 32'h5555_5555, rd); idle();
        do_xfer(0, 1'b0, 32'h0000_0002, 32'd0, rd); idle();
        do_xfer(0, 1'b0, 32'h0000_0040, 32'd0, rd); idle();
        do_xfer(0, 1'b0, 32'h0000_003C, 32'd0, rd); idle();
        check("cnt_after_illegal", rd, 32'd3);

        do_xfer(2, 1'b1, 32'h0000_0008, 32'h0000_0005, rd); idle();
        #1 cur = 2; sel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0000_0008; pwdata = 32'h0000_000A;
        @(posedge PCLK); #1 penable = 1'b1;
        @(posedge PCLK); #1 sel = '0; penable = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_pready", {31'd0, ready_m}, 32'd0);
        @(posedge PCLK);
        do_xfer(2, 1'b0, 32'h0000_0008, 32'd0, rd); idle();
        check("abort_no_write", rd, 32'd5);

        for (int i = 0; i < 120; i++) begin
            r  = int'($urandom_range(0, 9));
            wr = 1'($urandom_range(0, 1));
            a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (r == 7)      a[1:0] = 2'($urandom_range(1, 3));
            else if (r == 8) a[6 + ($urandom_range(0, 25))] = 1'b1;
            else if (r == 9) a[5:2] = 4'hF;
            do_xfer(i % 3, wr, a, $urandom, rd);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        #1 cur = 0; sel = 3'b001; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0000_0008; pwdata = 32'h0000_1234;
        @(posedge PCLK); #1 penable = 1'b1;
        @(posedge PCLK); #1 PRESETn = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("rst_mid_pready", {31'd0, ready_m}, 32'd0);
        check("rst_mid_prdata", rdata_m, 32'd0);
        @(posedge PCLK); #1 PRESETn = 1'b1; sel = '0; penable = 1'b0;
        model_reset();
        @(posedge PCLK);
        do_xfer(0, 1'b0, 32'h0000_0008, 32'd0, rd); idle();
        check("rst_reg8_zero", rd, 32'd0);
        do_xfer(0, 1'b0, 32'h0000_003C, 32'd0, rd); idle();
        check("rst_cnt_one", rd, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB completer that sits directly downstream of the APB_Master requester and terminates its PSELx/PENABLE transfers. It holds a bank of word-addressed registers. A programmable number of wait states is inserted through PREADY, and illegal accesses are flagged with PSLVERR. The top register is a read-only counter of completed good transfers, used for bring-up and bus-traffic checks.

Parameters:
DATA_WIDTH, 32, width of PWDATA/PRDATA and of every register
ADDR_WIDTH, 32, width of PADDR
NUM_REGS, 16, register count (power of 2, min 2); index NUM_REGS-1 is the read-only transfer counter
WAIT_CYCLES, 1, extra access-phase cycles with PREADY=0 before completion (0..15)

Ports:
PCLK  in  1  clock; all state changes on rising edge
PRESETn  in  1  reset, synchronous, active-low
PSELx  in  1  completer select
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PRDATA  out  DATA_WIDTH  read data, registered
PREADY  out  1  transfer completion, registered
PSLVERR  out  1  error response, valid only while PREADY=1, registered

Behaviour:
- Reset (PRESETn=0 at a rising edge):
  - state=IDLE, all registers=0, counter=0, PREADY=0, PRDATA=0, PSLVERR=0.
  - Reset mid-transfer abandons the transfer; no write occurs.
- Address decode:
  - idx = PADDR[2 +: log2(NUM_REGS)].
  - The access is illegal if PADDR[1:0]!=0, or if any PADDR bit above the index field is 1, or if it is a write to idx NUM_REGS-1.
- State machine: IDLE, WAIT, RESP.
  - IDLE: if PSELx=1 and PENABLE=0 (setup phase), go to WAIT and load cnt=WAIT_CYCLES; otherwise stay.
  - WAIT: requires PSELx=1 and PENABLE=1.
    - If cnt!=0: cnt decrements, PREADY stays 0.
    - If cnt==0: at this edge set PREADY=1, drive PSLVERR and PRDATA, commit the write, and go to RESP.
    - Result: exactly WAIT_CYCLES+1 access-phase cycles with PREADY=0 before the PREADY=1 cycle.
  - RESP: at the next edge clear PREADY, PSLVERR and PRDATA to 0, and go to IDLE.
    - If PSELx=1 and PENABLE=0 are sampled at that same edge (back-to-back setup), go to WAIT and load cnt instead.
  - Abort: PSELx=0 sampled in WAIT returns to IDLE with no write, no counter change, PREADY=0.
- Write:
  - Legal write: reg[idx] <= PWDATA at the PREADY-raising edge; PRDATA=0.
  - Illegal write: no state change, PSLVERR=1.
- Read:
  - Legal read: PRDATA=reg[idx], or the counter value before any increment at this edge.
  - Illegal read: PRDATA=0, PSLVERR=1.
- Counter:
  - Increments by 1 at every PREADY-raising edge with PSLVERR=0, reads and writes alike.
  - Wraps from all-ones to 0.
- Input sampling:
  - PADDR, PWRITE and PWDATA are sampled at the completing edge.
  - APB requires these to be stable from setup onward; no internal capture is required.
- Outputs stay quiet outside the response cycle: PSLVERR and PRDATA are never non-zero while PREADY=0.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding (IDLE/WAIT/RESP, 2 bits);
  - APB_DATA_W=32 and APB_ADDR_W=32 defaults;
  - an illegal-access cause enum (MISALIGNED, OUT_OF_RANGE, RO_WRITE), used by bench coverage.
- One sub-module is natural: apb_addr_decode. It is combinational and produces idx and the legal flag from PADDR/PWRITE.
- The FSM, wait counter, register array and transfer counter stay in apb_slave_regfile.

Test Plan:
- Reset, then with WAIT_CYCLES=1: write 0xDEADBEEF to 0x04, then read 0x04.
  - Each transfer has 2 access cycles with PREADY=0, then PREADY=1.
  - Read returns PRDATA=0xDEADBEEF with PSLVERR=0; counter reads 2.
- WAIT_CYCLES=0: back-to-back setups with no idle cycle between them.
  - PREADY=1 on the 2nd access cycle of each transfer.
  - Second transfer completes correctly; no stale PRDATA between the transfers.
- Illegal accesses each give PSLVERR=1 with PREADY=1 and the counter unchanged:
  - write 0x3C (counter register, with NUM_REGS=16); counter value is unchanged;
  - read 0x02 (misaligned): PRDATA=0;
  - read 0x40 (out of range): PRDATA=0.
- Abort: drop PSELx during WAIT with WAIT_CYCLES=3.
  - No write occurs; reg stays at its old value; PREADY stays 0; FSM returns to IDLE.
- Reset asserted during WAIT of a write to 0x08.
  - Next edge: PREADY=0, all registers=0, counter=0.
  - Subsequent read of 0x08 returns 0.
- Counter wrap: preload is not possible, so use DATA_WIDTH=4.
  - After 16 good transfers the counter reads 0.
